// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and round-transform helpers
package aes_pkg;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // byte k sits at bits [127-8k -: 8]; row k%4, column k/4
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[127-8*k -: 8] = s[127-8*((k%4) + 4*(((k/4) + (k%4)) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte combinational AES S-box lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = SBOX[a];
endmodule

// File: rtl/aes_cipher.sv
// aes_cipher: iterative AES-128 encryption, one round per clock with on-the-fly key expansion
module aes_cipher
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [0:Nk*32-1] in,
    input  logic [0:Nk*32-1] key,
    output logic [0:Nk*32-1] out,
    output logic           out_valid,
    output logic           busy
);
    localparam int Nkb = Nk * 32;

    if (Nk != 4 || Nr != 10) begin : g_bad_params
        $error("aes_cipher supports only Nk=4, Nr=10");
    end

    logic [127:0] state_q, state_d, rk_q, rk_d, out_q, out_d;
    logic [3:0]   round_q, round_d;
    logic         busy_q, busy_d, out_valid_q, out_valid_d;

    logic [127:0] sb, sr, rnd, rk_next;
    logic [31:0]  rw, sw, t, n0, n1, n2, n3;
    logic [7:0]   rc;
    logic         last;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (.a(state_q[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    end

    assign rw = rot_word(rk_q[31:0]);
    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_sbox u_sbox (.a(rw[31-8*i -: 8]), .y(sw[31-8*i -: 8]));
    end

    assign rc      = (round_q != 4'd0 && round_q <= 4'd10) ? RCON[round_q - 4'd1] : 8'h00;
    assign t       = sw ^ {rc, 24'h0};
    assign n0      = rk_q[127:96] ^ t;
    assign n1      = rk_q[95:64] ^ n0;
    assign n2      = rk_q[63:32] ^ n1;
    assign n3      = rk_q[31:0] ^ n2;
    assign rk_next = {n0, n1, n2, n3};
    assign last    = round_q == 4'(Nr);
    assign sr      = shift_rows(sb);
    // the final round skips MixColumns
    assign rnd     = (last ? sr : mix_columns(sr)) ^ rk_next;

    always_comb begin
        state_d     = state_q;
        rk_d        = rk_q;
        round_d     = round_q;
        busy_d      = busy_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (busy_q) begin
            state_d = rnd;
            rk_d    = rk_next;
            round_d = round_q + 4'd1;
            if (last) begin
                out_d       = rnd;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                round_d     = 4'd0;
            end
        end else if (start) begin
            state_d = in ^ key;
            rk_d    = key;
            round_d = 4'd1;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            rk_q        <= '0;
            round_q     <= '0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rk_q        <= rk_d;
            round_q     <= round_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q[Nkb-1:0];
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_aes_cipher.sv
// tb_aes_cipher: scoreboard bench for aes_cipher using FIPS-197 vectors and an independent byte-level AES model
module tb_aes_cipher;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [127:0] din = '0, kin = '0, dout;
    logic         out_valid, busy;

    always #5 clk = ~clk;

    aes_cipher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(din), .key(kin),
        .out(dout), .out_valid(out_valid), .busy(busy)
    );

    typedef struct {
        logic [127:0] data;
        int           cyc;
        string        name;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          checks = 0, failures = 0;
    logic [7:0]  sbx[256];

    localparam logic [127:0] B_IN  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_OUT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] P_IN  = 128'h0102030405060708090a0b0c0d0e0f00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s[16], t[16], w[176], tmp[4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = k[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                tmp[0] = sbx[w[4*i-3]] ^ rc;
                tmp[1] = sbx[w[4*i-2]];
                tmp[2] = sbx[w[4*i-1]];
                tmp[3] = sbx[w[4*i-4]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbx[s[i]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rd+i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // drives one start pulse; a pushed entry expects out_valid 11 counts after the drive point
    task automatic issue(input logic [127:0] i, input logic [127:0] k, input logic [127:0] e,
                         input string nm, input bit push);
        din = i;
        kin = k;
        start = 1'b1;
        if (push) sbq.push_back('{data: e, cyc: cyc + 11, name: nm});
        step(1);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 40 && sbq.size() != 0; t++) step(1);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout pending=%0d want=0", nm, sbq.size());
            sbq.delete();
        end
        step(2);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid got out=%h want no out_valid", dout);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_out"}, dout, e.data);
                chk({e.name, "_busy_at_valid"}, 128'(busy), 128'(0));
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s_latency got=%0d want=%0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = '0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbx[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        #3;
        chk("reset_out", dout, '0);
        chk("reset_valid", 128'(out_valid), '0);
        chk("reset_busy", 128'(busy), '0);
        step(1);
        rst_n = 1'b1;
        step(1);

        issue(B_IN, B_KEY, B_OUT, "appB", 1'b1);
        chk("appB_busy", 128'(busy), 128'(1));
        drain("appB");
        step(3);
        chk("appB_hold", dout, B_OUT);
        chk("idle_valid", 128'(out_valid), '0);
        chk("idle_busy", 128'(busy), '0);

        issue(C_IN, C_KEY, C_OUT, "appC", 1'b1);
        drain("appC");
        issue('0, '0, Z_OUT, "zero", 1'b1);
        drain("zero");
        issue(P_IN, '0, aes_ref(P_IN, '0), "model", 1'b1);
        drain("model");

        issue(C_IN, C_KEY, C_OUT, "midstart", 1'b1);
        step(3);
        din = B_IN;
        kin = B_KEY;
        start = 1'b1;
        step(1);
        start = 1'b0;
        din = 128'hdeadbeef_00000000_cafef00d_12345678;
        kin = 128'hffffffff_00000000_ffffffff_00000000;
        chk("midstart_busy", 128'(busy), 128'(1));
        drain("midstart");
        step(12);
        chk("midstart_hold", dout, C_OUT);

        issue('0, '0, Z_OUT, "b2b_first", 1'b1);
        step(10);
        issue(B_IN, B_KEY, B_OUT, "b2b_second", 1'b1);
        drain("b2b");

        issue(B_IN, B_KEY, B_OUT, "aborted", 1'b1);
        step(5);
        chk("abort_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("abort_busy", 128'(busy), '0);
        chk("abort_out", dout, '0);
        chk("abort_valid", 128'(out_valid), '0);
        step(2);
        rst_n = 1'b1;
        step(15);
        chk("post_abort_out", dout, '0);
        issue(B_IN, B_KEY, B_OUT, "after_reset", 1'b1);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
